btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised, direct-mapped branch target buffer with 2-bit saturating direction counters, serving the IF stage of the ThinPad pipeline.
- Same-cycle lookup on the fetch PC returns the predicted next PC.
- The EXE stage feeds back resolved branches. The block updates the table, flags mispredicts for IF/ID flush, and supplies the corrected PC.
- Adds tag compare, hysteresis counters, a bulk invalidate and performance counters.

Parameters:
- ADDR_W, 16, PC width in bits.
- ENTRIES, 16, table depth; power of two, 2..256. IDX_W = log2(ENTRIES).
- PC_STEP, 1, sequential PC increment (word-addressed).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cur_pc  in  ADDR_W  fetch PC for lookup.
- pred_hit  out  1  valid entry with matching tag at cur_pc.
- pred_taken  out  1  pred_hit & counter[1].
- pred_pc  out  ADDR_W  pred_taken ? stored target : cur_pc+PC_STEP.
- upd_valid  in  1  EXE stage resolved a branch/jump this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual target (meaningful when taken).
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  ADDR_W  predicted PC carried with the instruction.
- mispredict  out  1  flush request.
- correct_pc  out  ADDR_W  PC to redirect to on mispredict.
- clear  in  1  synchronous invalidate of all entries.
- upd_cnt  out  CNT_W  number of accepted updates.
- mispred_cnt  out  CNT_W  number of mispredicts.

Behaviour:
- Entry layout: valid, tag = pc[ADDR_W-1:IDX_W], target[ADDR_W], ctr[2]. Index = pc[IDX_W-1:0].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst=0, asynchronous): all valid=0, ctr=00, target=0, upd_cnt=0, mispred_cnt=0.
  - Consequence: pred_hit=0, pred_taken=0, pred_pc=cur_pc+PC_STEP.
  - With upd_valid=0: mispredict=0 and correct_pc=upd_pc+PC_STEP.
  - Reset asserted mid-run discards all state immediately.
- Lookup: purely combinational from cur_pc and the registered table, zero latency.
- Read/write ordering: an update to the same index in the same cycle is not visible until the next cycle. There is no write-through bypass.
- Mispredict (combinational, upd_valid required):
  - mispredict = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_target != upd_target).
  - correct_pc = upd_taken ? upd_target : upd_pc+PC_STEP.
- Table update on the clock edge when upd_valid=1 and clear=0:
  - Hit, taken: ctr saturating +1; target <= upd_target.
  - Hit, not taken: ctr saturating −1; target kept.
  - Miss, taken: allocate (overwrite any aliasing entry); valid=1, tag, target, ctr=10.
  - Miss, not taken: no change.
- PC arithmetic: all additions are modulo 2^ADDR_W; 16'hFFFF + 1 wraps to 0.
- clear=1: all valid bits are cleared at the next edge.
  - clear has priority over a simultaneous update, which is dropped from the table.
  - mispredict and correct_pc are still driven combinationally during clear.
- Stats:
  - upd_cnt increments on every upd_valid.
  - mispred_cnt increments on every mispredict.
  - Both saturate at all-ones and are unaffected by clear.

Test Plan:
1. Reset, then cur_pc=16'h0040 -> pred_hit=0, pred_taken=0, pred_pc=16'h0041; both counters 0.
2. Update pc=0x0040, taken, target=0x0080, pred_taken=0 -> mispredict=1, correct_pc=0x0080, mispred_cnt=1. Next cycle lookup 0x0040 -> hit, taken, pred_pc=0x0080. Same-cycle lookup returns miss.
3. Two NT updates on 0x0040 carrying pred_taken=1 -> each mispredict=1, correct_pc=0x0041. Counter goes 10->01->00; lookup gives pred_taken=0, pred_pc=0x0041; mispred_cnt=3, upd_cnt=3.
4. Alias: with 0x0040 resident, lookup 0x0050 (same index, different tag) -> miss. Taken update 0x0050->0x0100 replaces the entry; 0x0040 then misses.
5. Saturation and hysteresis: 4 taken updates (correct predictions, mispredict=0) -> ctr=11. One NT update -> ctr=10, still predicts taken. cur_pc=16'hFFFF miss -> pred_pc=16'h0000.
6. Control priority:
   - clear=1 with a simultaneous taken update -> next cycle all lookups miss; upd_cnt still increments.
   - rst pulled low between edges -> pred_hit falls without waiting for clk; stats read 0.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit hysteresis counters for the IF stage.
// Same-cycle lookup on the fetch PC; resolved branches from EXE update the table and raise flush requests.
module btb_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int PC_STEP = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cur_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc,
    input  logic              clear,
    output logic [CNT_W-1:0]  upd_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic              upd_hit;
    logic              wr_en;
    logic [1:0]        ctr_d;
    logic [ADDR_W-1:0] target_d;
    logic [CNT_W-1:0]  upd_cnt_q, upd_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    assign rd_idx     = cur_pc[IDX_W-1:0];
    assign pred_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == cur_pc[ADDR_W-1:IDX_W]);
    assign pred_taken = pred_hit && ctr_q[rd_idx][1];
    assign pred_pc    = pred_taken ? target_q[rd_idx] : cur_pc + STEP;

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + STEP;

    assign wr_idx  = upd_pc[IDX_W-1:0];
    assign wr_tag  = upd_pc[ADDR_W-1:IDX_W];
    assign upd_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Not-taken misses leave the table alone; taken misses evict whatever aliases the index.
    always_comb begin
        wr_en    = 1'b0;
        ctr_d    = ctr_q[wr_idx];
        target_d = target_q[wr_idx];
        if (upd_valid && !clear) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    ctr_d    = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'd1;
                    target_d = upd_target;
                end else begin
                    ctr_d    = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                wr_en    = 1'b1;
                ctr_d    = 2'b10;
                target_d = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= target_d;
            ctr_q[wr_idx]    <= ctr_d;
        end
    end

    // Statistics saturate and deliberately ignore clear.
    always_comb begin
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && (upd_cnt_q != '1)) begin
            upd_cnt_d = upd_cnt_q + 1'b1;
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_cnt     = upd_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: lookup, update, aliasing, saturation, clear and async reset.
module tb_btb_predictor;
    logic        clk;
    logic        rst;
    logic [15:0] cur_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] correct_pc;
    logic        clear;
    logic [15:0] upd_cnt;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    btb_predictor #(.ADDR_W(16), .ENTRIES(16), .PC_STEP(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cur_pc(cur_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .correct_pc(correct_pc), .clear(clear),
        .upd_cnt(upd_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                             input logic ptk, input logic [15:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; cur_pc = 16'h0040;
        upd_valid = 1'b0; upd_pc = 16'h0000; upd_taken = 1'b0; upd_target = 16'h0000;
        upd_pred_taken = 1'b0; upd_pred_target = 16'h0000;
        #1;
        chk("rst_hit", pred_hit, 0);
        chk("rst_taken", pred_taken, 0);
        chk("rst_pc", pred_pc, 16'h0041);
        chk("rst_updcnt", upd_cnt, 0);
        chk("rst_miscnt", mispred_cnt, 0);
        chk("rst_misp", mispredict, 0);
        chk("rst_corr", correct_pc, 16'h0001);
        #1 rst = 1'b1;
        step();

        // First taken update allocates; same-cycle lookup still misses
        drive_upd(16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0041);
        #1;
        chk("alloc_misp", mispredict, 1);
        chk("alloc_corr", correct_pc, 16'h0080);
        chk("alloc_samecyc_hit", pred_hit, 0);
        step();
        upd_valid = 1'b0;
        #1;
        chk("alloc_hit", pred_hit, 1);
        chk("alloc_taken", pred_taken, 1);
        chk("alloc_pc", pred_pc, 16'h0080);
        chk("alloc_miscnt", mispred_cnt, 1);

        // Two not-taken updates walk 10 -> 01 -> 00
        drive_upd(16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0080);
        #1;
        chk("nt1_misp", mispredict, 1);
        chk("nt1_corr", correct_pc, 16'h0041);
        step();
        #1;
        chk("nt1_taken", pred_taken, 0);
        chk("nt1_hit", pred_hit, 1);
        chk("nt2_misp", mispredict, 1);
        step();
        upd_valid = 1'b0;
        #1;
        chk("nt2_taken", pred_taken, 0);
        chk("nt2_pc", pred_pc, 16'h0041);
        chk("nt2_miscnt", mispred_cnt, 3);
        chk("nt2_updcnt", upd_cnt, 3);

        // Aliasing entry at the same index replaces 0x0040
        cur_pc = 16'h0050;
        #1;
        chk("alias_miss", pred_hit, 0);
        chk("alias_misspc", pred_pc, 16'h0051);
        drive_upd(16'h0050, 1'b1, 16'h0100, 1'b0, 16'h0051);
        step();
        upd_valid = 1'b0;
        #1;
        chk("alias_hit", pred_hit, 1);
        chk("alias_pc", pred_pc, 16'h0100);
        cur_pc = 16'h0040;
        #1;
        chk("alias_old_miss", pred_hit, 0);
        chk("alias_old_pc", pred_pc, 16'h0041);

        // Saturation at 11, then hysteresis
        cur_pc = 16'h0050;
        for (int i = 0; i < 4; i++) begin
            drive_upd(16'h0050, 1'b1, 16'h0100, 1'b1, 16'h0100);
            #1;
            chk("sat_misp", mispredict, 0);
            step();
        end
        drive_upd(16'h0050, 1'b0, 16'h0000, 1'b1, 16'h0100);
        step();
        upd_valid = 1'b0;
        #1;
        chk("hyst_taken", pred_taken, 1);
        chk("hyst_pc", pred_pc, 16'h0100);
        drive_upd(16'h0050, 1'b0, 16'h0000, 1'b1, 16'h0100);
        step();
        upd_valid = 1'b0;
        #1;
        chk("hyst2_taken", pred_taken, 0);
        chk("hyst2_pc", pred_pc, 16'h0051);
        drive_upd(16'h0050, 1'b1, 16'h0100, 1'b1, 16'h0200);
        #1;
        chk("tgt_misp", mispredict, 1);
        chk("tgt_corr", correct_pc, 16'h0100);
        step();
        chk("tgt_miscnt", mispred_cnt, 7);
        chk("tgt_updcnt", upd_cnt, 11);

        // PC wrap on both lookup and correction paths
        cur_pc = 16'hFFFF;
        drive_upd(16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        chk("wrap_hit", pred_hit, 0);
        chk("wrap_pc", pred_pc, 16'h0000);
        chk("wrap_misp", mispredict, 0);
        chk("wrap_corr", correct_pc, 16'h0000);
        step();
        chk("wrap_updcnt", upd_cnt, 12);

        // Clear wins over a simultaneous taken update
        clear = 1'b1;
        drive_upd(16'h0060, 1'b1, 16'h0300, 1'b0, 16'h0061);
        #1;
        chk("clr_misp", mispredict, 1);
        chk("clr_corr", correct_pc, 16'h0300);
        step();
        clear = 1'b0;
        upd_valid = 1'b0;
        cur_pc = 16'h0050;
        #1;
        chk("clr_miss50", pred_hit, 0);
        cur_pc = 16'h0060;
        #1;
        chk("clr_miss60", pred_hit, 0);
        chk("clr_updcnt", upd_cnt, 13);
        chk("clr_miscnt", mispred_cnt, 8);

        // Asynchronous reset between edges
        cur_pc = 16'h0040;
        drive_upd(16'h0040, 1'b1, 16'h0080, 1'b1, 16'h0080);
        step();
        upd_valid = 1'b0;
        #1;
        chk("pre_rst_hit", pred_hit, 1);
        rst = 1'b0;
        #1;
        chk("arst_hit", pred_hit, 0);
        chk("arst_pc", pred_pc, 16'h0041);
        chk("arst_updcnt", upd_cnt, 0);
        chk("arst_miscnt", mispred_cnt, 0);
        #1 rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
